// File: rtl/akarin_pkg.sv
// Shared bus types for the instruction-memory bus.
// Request and response bundles plus the byte-enable width.
package akarin_pkg;

    localparam int MEM_BE_W = 4;

    typedef struct packed {
        logic [31:0]         addr;
        logic                we;
        logic [MEM_BE_W-1:0] be;
        logic [31:0]         wdata;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        rerr;
    } mem_rsp_t;

endpackage

// File: rtl/inst_mem_responder_resp_fifo.sv
// In-order response queue between the read pipeline and the bus.
// Head is presented combinationally; depth equals the credit count.
module resp_fifo
    import akarin_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  mem_rsp_t data_i,
    input  logic     pop_i,
    output mem_rsp_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    mem_rsp_t      mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] wrap_inc(logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = do_push ? wrap_inc(wr_q) : wr_q;
        rd_d  = do_pop ? wrap_inc(rd_q) : rd_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory slave: byte-enabled RAM, fixed-latency responses,
// credit-limited outstanding requests, alignment/range error reporting.
module inst_mem_responder
    import akarin_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 1,
    parameter int MAX_OUTST   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    output logic                gnt,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                we,
    input  logic [MEM_BE_W-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic                rerr
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH_WORDS * 4);

    logic [DATA_W-1:0] ram [DEPTH_WORDS];
    logic [CW-1:0]     outst_q, outst_d;
    logic              open_q;
    logic              accept, pop, err;
    logic              push, fifo_full, fifo_empty;
    logic [IW-1:0]     widx;
    mem_req_t          req_s;
    mem_rsp_t          rsp_new, push_rsp, head;

    assign req_s = '{addr: 32'(addr), we: we, be: be, wdata: 32'(wdata)};

    // open_q delays grants by one cycle after reset release.
    assign gnt    = open_q && (outst_q < CW'(MAX_OUTST));
    assign accept = req && gnt;
    assign pop    = rvalid && rready;
    assign widx   = req_s.addr[IW+1:2];
    assign err    = (req_s.addr[1:0] != 2'b00) || ({1'b0, addr} >= LIMIT);

    assign rsp_new.rerr  = err;
    assign rsp_new.rdata = (req_s.we || err) ? '0 : ram[widx];

    always_ff @(posedge clk) begin
        if (accept && req_s.we && !err) begin
            for (int i = 0; i < MEM_BE_W; i++) begin
                if (req_s.be[i]) begin
                    ram[widx][8*i +: 8] <= req_s.wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        outst_d = outst_q;
        unique case ({accept, pop})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outst_q <= '0;
            open_q  <= 1'b0;
        end else begin
            outst_q <= outst_d;
            open_q  <= 1'b1;
        end
    end

    if (LATENCY == 1) begin : g_direct
        assign push     = accept;
        assign push_rsp = rsp_new;
    end else begin : g_pipe
        logic [LATENCY-2:0] v_q;
        mem_rsp_t           r_q [LATENCY-1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q <= '0;
                for (int i = 0; i < LATENCY - 1; i++) begin
                    r_q[i] <= '0;
                end
            end else begin
                v_q[0] <= accept;
                r_q[0] <= rsp_new;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    v_q[i] <= v_q[i-1];
                    r_q[i] <= r_q[i-1];
                end
            end
        end

        assign push     = v_q[LATENCY-2];
        assign push_rsp = r_q[LATENCY-2];
    end

    resp_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .data_i  (push_rsp),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Credits bound pipeline plus queue, so a push never meets a full queue.
    assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

    assign rvalid = !fifo_empty;
    assign rdata  = rvalid ? DATA_W'(head.rdata) : '0;
    assign rerr   = rvalid && head.rerr;

endmodule
